// File: rtl/bin_a_bcd_if.sv
// Start/done handshake and data bus between a producer (e.g. raiz) and bin_a_bcd.
// The master drives the start request and value; the slave returns the result.
interface bin_a_bcd_if #(
   parameter int unsigned ANCHO   = 16,
   parameter int unsigned DIGITOS = 5
);
   logic                   iniciar;
   logic [ANCHO-1:0]       binario;
   logic [4*DIGITOS-1:0]   bcd;
   logic                   terminado;
   logic                   ocupado;

   modport master (
      output iniciar,
      output binario,
      input  bcd,
      input  terminado,
      input  ocupado
   );

   modport slave (
      input  iniciar,
      input  binario,
      output bcd,
      output terminado,
      output ocupado
   );
endinterface

// File: rtl/bin_a_bcd.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one shift per clock.
// All outputs are registered; a conversion takes ANCHO cycles after acceptance.
module bin_a_bcd #(
   parameter int unsigned ANCHO   = 16,
   parameter int unsigned DIGITOS = 5
) (
   input logic          clk,
   input logic          rst_n,
   bin_a_bcd_if.slave   bus
);
   localparam int unsigned AnchoBcd = 4 * DIGITOS;
   localparam int unsigned AnchoReg = AnchoBcd + ANCHO;
   localparam int unsigned AnchoCnt = $clog2(ANCHO + 1);

   typedef enum logic [0:0] {StReposo, StConvertir} estado_t;

   estado_t               estado;
   logic [AnchoReg-1:0]   desp;
   logic [AnchoCnt-1:0]   cnt;
   logic [AnchoReg-1:0]   ajustado;
   logic [AnchoReg-1:0]   desplazado;

   // Nibble-local +3 correction on the BCD part, then a 1-bit left shift.
   always_comb begin
      ajustado = desp;
      for (int i = 0; i < int'(DIGITOS); i++) begin
         if (desp[ANCHO + 4*i +: 4] >= 4'd5) begin
            ajustado[ANCHO + 4*i +: 4] = desp[ANCHO + 4*i +: 4] + 4'd3;
         end
      end
      desplazado = {ajustado[AnchoReg-2:0], 1'b0};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         estado        <= StReposo;
         desp          <= '0;
         cnt           <= '0;
         bus.bcd       <= '0;
         bus.terminado <= 1'b0;
         bus.ocupado   <= 1'b0;
      end else begin
         unique case (estado)
            StReposo: begin
               bus.terminado <= 1'b0;
               if (bus.iniciar) begin
                  desp        <= {{AnchoBcd{1'b0}}, bus.binario};
                  cnt         <= '0;
                  bus.ocupado <= 1'b1;
                  estado      <= StConvertir;
               end
            end
            StConvertir: begin
               desp <= desplazado;
               cnt  <= cnt + 1'b1;
               if (cnt == AnchoCnt'(ANCHO - 1)) begin
                  bus.bcd       <= desplazado[AnchoReg-1 -: AnchoBcd];
                  bus.terminado <= 1'b1;
                  bus.ocupado   <= 1'b0;
                  estado        <= StReposo;
               end
            end
            default: estado <= StReposo;
         endcase
      end
   end
endmodule

// File: tb/tb_bin_a_bcd.sv
// Directed and randomized bench for bin_a_bcd against a decimal-arithmetic model.
module tb_bin_a_bcd;
   localparam int unsigned ANCHO   = 16;
   localparam int unsigned DIGITOS = 5;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   bin_a_bcd_if #(.ANCHO(ANCHO), .DIGITOS(DIGITOS)) bus ();

   bin_a_bcd #(.ANCHO(ANCHO), .DIGITOS(DIGITOS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   function automatic logic [19:0] ref_bcd(input int unsigned v);
      logic [19:0] r;
      r = '0;
      for (int i = 0; i < int'(DIGITOS); i++) begin
         r[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   function automatic int unsigned isqrt(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((r + 1) * (r + 1) <= v) r++;
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One conversion; binario is scrambled during it to show it has no effect.
   task automatic run_conv(input logic [15:0] v, input string tag);
      int k;
      bit got;
      int ocup_bad;
      @(negedge clk);
      bus.iniciar = 1'b1;
      bus.binario = v;
      @(negedge clk);
      bus.iniciar = 1'b0;
      check({tag, " ocupado_start"}, 32'(bus.ocupado), 32'd1);
      k = 0;
      got = 1'b0;
      ocup_bad = 0;
      while (!got && k < 40) begin
         @(negedge clk);
         k++;
         bus.binario = 16'($urandom);
         if (bus.terminado) got = 1'b1;
         else if (bus.ocupado !== 1'b1) ocup_bad++;
      end
      check({tag, " latency"}, 32'(k), 32'd16);
      check({tag, " bcd"}, 32'(bus.bcd), 32'(ref_bcd(32'(v))));
      check({tag, " ocupado_done"}, 32'(bus.ocupado), 32'd0);
      check({tag, " ocupado_during"}, 32'(ocup_bad), 32'd0);
      @(negedge clk);
      check({tag, " terminado_drop"}, 32'(bus.terminado), 32'd0);
   endtask

   initial begin
      int pulses;
      int bad;
      int last;
      logic [19:0] seen;
      bus.iniciar = 1'b0;
      bus.binario = '0;

      repeat (3) @(negedge clk);
      check("reset bcd", 32'(bus.bcd), 32'd0);
      check("reset terminado", 32'(bus.terminado), 32'd0);
      check("reset ocupado", 32'(bus.ocupado), 32'd0);
      rst_n = 1'b1;

      run_conv(16'd0, "zero");
      run_conv(16'd12, "twelve");
      run_conv(16'd65535, "max");
      run_conv(16'd9999, "9999");
      run_conv(16'd10000, "10000");

      for (int i = 0; i < 12; i++) run_conv(16'($urandom_range(0, 65535)), "random");

      // Start request during a conversion is ignored.
      @(negedge clk);
      bus.iniciar = 1'b1;
      bus.binario = 16'd255;
      @(negedge clk);
      bus.iniciar = 1'b0;
      repeat (4) @(negedge clk);
      bus.iniciar = 1'b1;
      bus.binario = 16'd999;
      @(negedge clk);
      bus.iniciar = 1'b0;
      pulses = 0;
      seen = '0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (bus.terminado) begin
            pulses++;
            seen = bus.bcd;
         end
      end
      check("busy_ignore pulses", 32'(pulses), 32'd1);
      check("busy_ignore bcd", 32'(seen), 32'(ref_bcd(255)));

      // Continuous start: back-to-back conversions every ANCHO+1 cycles.
      @(negedge clk);
      bus.iniciar = 1'b1;
      bus.binario = 16'd4321;
      pulses = 0;
      bad = 0;
      last = -1;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         if (bus.ocupado === bus.terminado) bad++;
         if (bus.terminado) begin
            pulses++;
            if (bus.bcd !== ref_bcd(4321)) bad++;
            if (last >= 0 && k - last != 17) bad++;
            last = k;
         end
      end
      bus.iniciar = 1'b0;
      check("held pulses", 32'(pulses), 32'd3);
      check("held consistency", 32'(bad), 32'd0);
      repeat (20) @(negedge clk);

      // Reset in the middle of a conversion discards it.
      run_conv(16'd77, "pre_reset");
      @(negedge clk);
      bus.iniciar = 1'b1;
      bus.binario = 16'd500;
      @(negedge clk);
      bus.iniciar = 1'b0;
      repeat (7) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("midreset bcd", 32'(bus.bcd), 32'd0);
      check("midreset ocupado", 32'(bus.ocupado), 32'd0);
      check("midreset terminado", 32'(bus.terminado), 32'd0);
      rst_n = 1'b1;
      pulses = 0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (bus.terminado !== 1'b0 || bus.ocupado !== 1'b0) pulses++;
      end
      check("post_reset idle", 32'(pulses), 32'd0);

      // Square-root results fed straight in, as the upstream unit would.
      run_conv(16'(isqrt(144)), "chain_144");
      run_conv(16'(isqrt(2)), "chain_2");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/bin_a_bcd.md
Name: bin_a_bcd

Overview:
Sequential binary-to-BCD converter using the shift-and-add-3 (double dabble) method. It sits directly downstream of the square-root unit (raiz). It takes the 16-bit result as an unsigned binary value and produces packed BCD digits for the calculator display stage. It uses the same start/done handshake as raiz: a one-cycle iniciar pulse starts a conversion and a one-cycle terminado pulse reports completion, so raiz.terminado can drive iniciar directly.

Parameters:
ANCHO, 16, width of the unsigned binary input.
DIGITOS, 5, number of BCD output digits; must satisfy 10^DIGITOS > 2^ANCHO - 1 (the default 5 covers 65535).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  reset, synchronous, active-low.
iniciar  input  1  start request; sampled only in state REPOSO.
binario  input  ANCHO  unsigned value to convert; captured on the accepting edge.
bcd  output  4*DIGITOS  packed BCD result, digit 0 (units) in bits [3:0]; registered.
terminado  output  1  one-cycle pulse when bcd has been updated with a new result.
ocupado  output  1  high while a conversion is in progress.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset (rst_n low at a rising edge):
  - bcd = 0, terminado = 0, ocupado = 0.
  - Internal shift register and counter cleared; FSM goes to REPOSO.
  - Reset overrides everything, including a conversion in progress: the partial result is discarded and bcd is not updated.
- FSM states: REPOSO, CONVERTIR.
- REPOSO, with iniciar = 1 at edge N:
  - Load the shift register with {4*DIGITOS zeros, binario}.
  - Clear the counter; set ocupado = 1; go to CONVERTIR.
  - With iniciar = 0, stay in REPOSO; bcd holds its last value.
- CONVERTIR, at each edge:
  - First, every 4-bit BCD nibble of the shift register that is >= 5 gets +3 (nibble-local, no carry between nibbles).
  - Then the whole register shifts left by 1 and the counter increments.
  - Exactly ANCHO shifts are performed, at edges N+1 .. N+ANCHO.
- Completion at edge N+ANCHO (the final shift):
  - bcd gets the upper 4*DIGITOS bits of the post-shift value.
  - terminado = 1, ocupado = 0, FSM returns to REPOSO.
  - At edge N+ANCHO+1, terminado returns to 0 unconditionally.
- Latency: iniciar accepted at edge N gives terminado high in the cycle after edge N+ANCHO (16 cycles for the default). bcd is valid in that same cycle and holds until the next completion or reset.
- iniciar while ocupado = 1: ignored, with no restart and no queueing. binario changes during a conversion have no effect.
- iniciar held high continuously: a new conversion is accepted at edge N+ANCHO+1, the same edge at which terminado drops. This gives back-to-back conversions every ANCHO+1 cycles.
- iniciar = 1 in the same cycle that terminado = 1: accepted (the FSM is already in REPOSO).
- Arithmetic:
  - The shift register is 4*DIGITOS + ANCHO bits wide.
  - The counter is clog2(ANCHO+1) bits wide.
  - Each output nibble is always in the range 0..9; no overflow is possible given the parameter rule.
- No combinational path from inputs to outputs; every output is driven from a flop.

Test Plan:
- Reset; binario=0, pulse iniciar -> terminado pulses exactly 16 cycles after the accepting edge, bcd=20'h00000, ocupado high for those 16 cycles.
- binario=12 (raiz result of 144) -> bcd=20'h00012; then binario=65535 -> bcd=20'h65535; binario=9999 -> bcd=20'h09999; binario=10000 -> bcd=20'h10000.
- Start with binario=255; at cycle 5 of the conversion, pulse iniciar with binario=999 -> single terminado pulse, bcd=20'h00255, no second conversion.
- Hold iniciar=1 with binario=4321 -> terminado pulses every 17 cycles, bcd=20'h04321 each time, ocupado low only in the terminado cycles.
- Complete a conversion of 77 (bcd=20'h00077), start a conversion of 500, assert rst_n=0 at cycle 8 -> next edge gives bcd=0, ocupado=0, terminado=0; no terminado afterward until a new iniciar.
- Chain raiz -> bin_a_bcd: radicando=144 then radicando=2, with raiz.terminado driving iniciar -> bcd=20'h00012 then 20'h00001.
